// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multi-cycle control unit: opcodes, FSM states and the
// datapath control bundle produced by the opcode decoder.
package riscv_ctrl_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned ALU_OP_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LD   = 3'b000,
        OP_SD   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_ADDI = 3'b111
    } opcode_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic                beq;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to base control bundle; the FSM decides which strobes are live per state.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  opcode_t op,
    output ctrl_t   ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (op)
            OP_LD: begin
                ctrl_c.alu_op     = ALU_ADD;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
            end
            OP_SD: begin
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
            end
            OP_ADD: begin
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.reg_write = 1'b1;
            end
            OP_SUB: begin
                ctrl_c.alu_op    = ALU_SUB;
                ctrl_c.reg_write = 1'b1;
            end
            OP_AND: begin
                ctrl_c.alu_op    = ALU_AND;
                ctrl_c.reg_write = 1'b1;
            end
            OP_OR: begin
                ctrl_c.alu_op    = ALU_OR;
                ctrl_c.reg_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_c.alu_op = ALU_SUB;
                ctrl_c.beq    = 1'b1;
            end
            OP_ADDI: begin
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.reg_write = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing with memory
// ready handshake, timeout watchdog, run/park control and retire counter.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                beq,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy,
    output logic                fault,
    output logic [RET_W-1:0]    retired
);

    localparam int unsigned WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t           state_q;
    state_t           state_d;
    opcode_t          op_q;
    logic [WD_W-1:0]  wd_cnt;
    logic [RET_W-1:0] ret_q;
    logic             fault_q;
    ctrl_t            base;
    ctrl_t            strobe;
    logic             ir_sel;
    logic             pc_sel;
    logic             retire;
    logic             wd_expired;

    ctrl_decode u_decode (
        .op     (op_q),
        .ctrl_c (base)
    );

    assign wd_expired = (MEM_TIMEOUT != 0) && (wd_cnt == WD_W'(TO_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus Moore strobe decode; SD completion pulses pc_write on mem_ready.
    always_comb begin
        state_d = state_q;
        strobe  = '0;
        ir_sel  = 1'b0;
        pc_sel  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_sel  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                strobe.alu_op  = base.alu_op;
                strobe.alu_src = base.alu_src;
                if (base.beq) begin
                    strobe.beq = 1'b1;
                    pc_sel     = 1'b1;
                    retire     = 1'b1;
                end else if (base.mem_read || base.mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                strobe.alu_op    = ALU_ADD;
                strobe.alu_src   = 1'b1;
                strobe.mem_read  = base.mem_read;
                strobe.mem_write = base.mem_write;
                if (mem_ready) begin
                    if (base.mem_write) begin
                        pc_sel = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                strobe.reg_write  = base.reg_write;
                strobe.mem_to_reg = base.mem_to_reg;
                strobe.alu_op     = base.alu_op;
                strobe.alu_src    = base.alu_src;
                pc_sel            = 1'b1;
                retire            = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    // Opcode capture, watchdog, retire counter and sticky fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= OP_LD;
            wd_cnt  <= '0;
            ret_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state_q == S_DECODE) op_q <= opcode_t'(opcode);
            if (state_q == S_MEM && state_d == S_MEM) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (retire) ret_q <= ret_q + RET_W'(1);
            if (state_d == S_FAULT) fault_q <= 1'b1;
        end
    end

    assign ir_write   = ir_sel;
    assign pc_write   = pc_sel;
    assign beq        = strobe.beq;
    assign mem_read   = strobe.mem_read;
    assign mem_write  = strobe.mem_write;
    assign alu_src    = strobe.alu_src;
    assign mem_to_reg = strobe.mem_to_reg;
    assign reg_write  = strobe.reg_write;
    assign alu_op     = strobe.alu_op;
    assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault      = fault_q;
    assign retired    = ret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction cycle model with a
// per-cycle compare of every output, plus literal checks on key behaviours.
module tb_multicycle_control_unit;

    localparam int TO = 4;
    localparam int RW = 2;

    localparam logic [2:0] OPC_LD   = 3'd0;
    localparam logic [2:0] OPC_SD   = 3'd1;
    localparam logic [2:0] OPC_ADD  = 3'd2;
    localparam logic [2:0] OPC_SUB  = 3'd3;
    localparam logic [2:0] OPC_AND  = 3'd4;
    localparam logic [2:0] OPC_OR   = 3'd5;
    localparam logic [2:0] OPC_BEQ  = 3'd6;
    localparam logic [2:0] OPC_ADDI = 3'd7;

    typedef struct packed {
        logic          ir_write;
        logic          pc_write;
        logic          beq;
        logic          mem_read;
        logic          mem_write;
        logic          alu_src;
        logic          mem_to_reg;
        logic          reg_write;
        logic [1:0]    alu_op;
        logic          busy;
        logic          fault;
        logic [RW-1:0] retired;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [2:0]    opcode;
    logic          mem_ready;
    logic          ir_write, pc_write, beq, mem_read, mem_write;
    logic          alu_src, mem_to_reg, reg_write, busy, fault;
    logic [1:0]    alu_op;
    logic [RW-1:0] retired;

    multicycle_control_unit #(.MEM_TIMEOUT(TO), .RET_W(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .beq        (beq),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .busy       (busy),
        .fault      (fault),
        .retired    (retired)
    );

    vec_t dut_vec;
    assign dut_vec = {ir_write, pc_write, beq, mem_read, mem_write, alu_src,
                      mem_to_reg, reg_write, alu_op, busy, fault, retired};

    vec_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            m_ret  = 0;
    bit            m_fault = 1'b0;
    int            rd_cnt = 0, wr_cnt = 0, rw_cnt = 0;
    logic [RW-1:0] ret_hist[$];
    logic [RW-1:0] last_ret = '0;
    bit            rec_en = 1'b0;

    always #5 clk = ~clk;

    // Single compare point: every pushed expectation is checked at the falling edge.
    always @(negedge clk) begin
        vec_t e;
        cyc++;
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
        if (reg_write) rw_cnt++;
        if (rec_en && retired != last_ret) ret_hist.push_back(retired);
        last_ret = retired;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL outs cyc=%0d got=%b want=%b (ir pc beq rd wr src m2r rw alu busy fault ret)",
                         cyc, dut_vec, e);
            end
        end
    end

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    function automatic logic [1:0] alu_of(input logic [2:0] op);
        case (op)
            OPC_SUB, OPC_BEQ: return 2'b01;
            OPC_AND:          return 2'b10;
            OPC_OR:           return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic logic imm_of(input logic [2:0] op);
        return (op == OPC_LD) || (op == OPC_SD) || (op == OPC_ADDI);
    endfunction

    function automatic vec_t base(input logic bsy);
        vec_t v;
        v         = '0;
        v.busy    = bsy;
        v.fault   = m_fault;
        v.retired = RW'(m_ret);
        return v;
    endfunction

    task automatic step(input logic r, input logic [2:0] opc, input logic mr, input vec_t e);
        @(posedge clk);
        #1;
        run       = r;
        opcode    = opc;
        mem_ready = mr;
        exp_q.push_back(e);
    endtask

    // IDLE or FAULT cycle: no strobes, not busy.
    task automatic park_step(input logic r);
        step(r, 3'($urandom), 1'($urandom), base(1'b0));
    endtask

    // One instruction from FETCH; k = MEM cycles before ready (-1 = never ready).
    task automatic do_instr(input logic [2:0] op, input int k, input logic run_end, output int ncyc);
        vec_t e;
        logic rdy;
        bit   is_mem;
        ncyc   = 0;
        is_mem = (op == OPC_LD) || (op == OPC_SD);
        e = base(1'b1); e.ir_write = 1'b1;
        step(1'b1, 3'($urandom), 1'($urandom), e); ncyc++;
        e = base(1'b1);
        step(1'b1, op, 1'($urandom), e); ncyc++;
        e = base(1'b1); e.alu_op = alu_of(op); e.alu_src = imm_of(op);
        if (op == OPC_BEQ) begin
            e.beq = 1'b1; e.pc_write = 1'b1;
            step(run_end, 3'($urandom), 1'($urandom), e); ncyc++;
            m_ret++;
            return;
        end
        step(run_end, 3'($urandom), 1'($urandom), e); ncyc++;
        if (is_mem) begin
            for (int i = 0; i < 64; i++) begin
                rdy = (k >= 0) && (i == k);
                e = base(1'b1);
                e.alu_src   = 1'b1;
                e.mem_read  = (op == OPC_LD);
                e.mem_write = (op == OPC_SD);
                e.pc_write  = (op == OPC_SD) && rdy;
                step(run_end, 3'($urandom), rdy, e); ncyc++;
                if (rdy && op == OPC_SD) begin
                    m_ret++;
                    return;
                end
                if (rdy) break;
                if (i == TO - 1) begin
                    m_fault = 1'b1;
                    return;
                end
            end
        end
        e = base(1'b1);
        e.reg_write  = 1'b1;
        e.mem_to_reg = (op == OPC_LD);
        e.alu_op     = alu_of(op);
        e.alu_src    = imm_of(op);
        e.pc_write   = 1'b1;
        step(run_end, 3'($urandom), 1'($urandom), e); ncyc++;
        m_ret++;
    endtask

    initial begin
        int   n;
        int   want_hist[5];
        vec_t e;
        want_hist = '{1, 2, 3, 0, 1};
        rst = 1'b1; run = 1'b0; opcode = '0; mem_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outs", int'(dut_vec), 0);
        @(posedge clk); #1 rst = 1'b1;

        park_step(1'b1);
        do_instr(OPC_ADD, 0, 1'b0, n);
        check("add_latency", n, 4);
        park_step(1'b0);
        check("add_retired", int'(retired), 1);

        park_step(1'b1);
        rd_cnt = 0;
        do_instr(OPC_LD, 2, 1'b0, n);
        check("ld_latency", n, 7);
        check("ld_read_cycles", rd_cnt, 3);
        park_step(1'b0);

        wr_cnt = 0; rw_cnt = 0;
        park_step(1'b1);
        do_instr(OPC_SD, 2, 1'b0, n);
        park_step(1'b0);
        check("sd_latency", n, 6);
        check("sd_write_cycles", wr_cnt, 3);
        check("sd_no_reg_write", rw_cnt, 0);

        rw_cnt = 0;
        park_step(1'b1);
        do_instr(OPC_BEQ, 0, 1'b0, n);
        park_step(1'b0);
        check("beq_latency", n, 3);
        check("beq_no_reg_write", rw_cnt, 0);
        check("beq_retired_wrap", int'(retired), 0);

        park_step(1'b1);
        do_instr(OPC_SUB, 0, 1'b0, n);
        park_step(1'b1);
        do_instr(OPC_OR, 0, 1'b1, n);
        do_instr(OPC_AND, 0, 1'b1, n);
        do_instr(OPC_SD, TO - 1, 1'b0, n);
        check("sd_ready_at_limit_latency", n, 7);
        park_step(1'b0);
        check("sd_ready_at_limit_no_fault", int'(fault), 0);

        park_step(1'b1);
        do_instr(OPC_SD, -1, 1'b1, n);
        check("timeout_cycles", n, 7);
        repeat (3) park_step(1'b1);
        check("fault_flag", int'(fault), 1);
        check("fault_not_busy", int'(busy), 0);

        @(negedge clk); #2 rst = 1'b0; run = 1'b0;
        #1 check("rst_clears_fault", int'(dut_vec), 0);
        m_fault = 1'b0; m_ret = 0;
        @(posedge clk); #1 rst = 1'b1;
        ret_hist.delete();
        rec_en = 1'b1;

        park_step(1'b1);
        for (int i = 0; i < 5; i++) do_instr(OPC_ADDI, 0, (i < 4), n);
        park_step(1'b0);
        @(negedge clk); #1;
        rec_en = 1'b0;
        check("ret_hist_len", ret_hist.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ret_hist.size()) check($sformatf("ret_hist_%0d", i), int'(ret_hist[i]), want_hist[i]);
        end

        park_step(1'b1);
        e = base(1'b1); e.ir_write = 1'b1;
        step(1'b1, 3'($urandom), 1'($urandom), e);
        e = base(1'b1);
        step(1'b1, OPC_LD, 1'($urandom), e);
        e = base(1'b1); e.alu_src = 1'b1;
        step(1'b1, 3'($urandom), 1'($urandom), e);
        e = base(1'b1); e.alu_src = 1'b1; e.mem_read = 1'b1;
        step(1'b1, 3'($urandom), 1'b0, e);
        @(negedge clk); #2 rst = 1'b0; run = 1'b0;
        #1 check("rst_in_mem", int'(dut_vec), 0);
        m_ret = 0;
        @(posedge clk); #1 rst = 1'b1;

        park_step(1'b1);
        do_instr(OPC_ADD, 0, 1'b0, n);
        park_step(1'b0);
        check("ret_after_mid_reset", int'(retired), 1);

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
